// File: rtl/nn_mac_sequencer.sv
// rtl/nn_mac_sequencer.sv - 4-3-1 neural net evaluated on one time-shared multiplier and accumulator
// Hidden neurons take 5 cycles each (4 MAC terms + bias/saturate), the output neuron 4 cycles.

module nn_mac_sequencer #(
  parameter int W_W = 8,
  parameter int R_W = 11
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [1:0]     in1,
  input  logic [1:0]     in2,
  input  logic [1:0]     in3,
  input  logic [1:0]     in4,
  input  logic [2:0]     bias1,
  input  logic [2:0]     bias2,
  input  logic [2:0]     bias3,
  input  logic [2:0]     bias4,
  input  logic           w_wr_en,
  input  logic [3:0]     w_addr,
  input  logic [W_W-1:0] w_data,
  output logic           busy,
  output logic           done,
  output logic           w_err,
  output logic           sat,
  output logic [R_W-1:0] h1_out,
  output logic [R_W-1:0] h2_out,
  output logic [R_W-1:0] h3_out,
  output logic [R_W-1:0] out_o1
);

  localparam int FRAC  = 8;
  localparam int ACC_W = R_W + 3;
  localparam int P_W   = R_W + W_W;
  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'((1 << R_W) - 1);

  typedef enum logic [1:0] {IDLE, HID, OUT, DONE} state_t;

  state_t           r_state;
  logic [1:0]       r_in   [4];
  logic [2:0]       r_bias [4];
  logic [W_W-1:0]   r_w    [15];
  logic [ACC_W-1:0] r_acc;
  logic [1:0]       r_neu;
  logic [2:0]       r_step;
  logic [R_W-1:0]   r_h1, r_h2, r_h3, r_o1;
  logic             r_busy, r_done, r_w_err, r_sat;

  logic [3:0]       w_widx;
  logic [R_W-1:0]   w_mul_a;
  logic [W_W-1:0]   w_mul_b;
  logic [2:0]       w_bias;
  logic [P_W-1:0]   w_prod;
  logic [ACC_W-1:0] w_prod_sh;
  logic [ACC_W-1:0] w_term;
  logic [ACC_W-1:0] w_biased;
  logic             w_over;
  logic [R_W-1:0]   w_result;

  // Operand select: hidden layer walks w(4n+1..4n+4) over the latched inputs,
  // output layer walks w13..w15 over this run's hidden results.
  always_comb begin
    w_widx  = '0;
    w_mul_a = '0;
    w_bias  = '0;
    case (r_state)
      OUT: begin
        w_widx = 4'd12 + {2'b00, r_step[1:0]};
        w_bias = r_bias[3];
        case (r_step[1:0])
          2'd0:    w_mul_a = r_h1;
          2'd1:    w_mul_a = r_h2;
          default: w_mul_a = r_h3;
        endcase
      end
      default: begin
        w_widx  = {r_neu, r_step[1:0]};
        w_bias  = r_bias[r_neu];
        w_mul_a = {{(R_W-2){1'b0}}, r_in[r_step[1:0]]};
      end
    endcase
  end

  assign w_mul_b   = (w_widx == 4'd15) ? '0 : r_w[w_widx];
  assign w_prod    = {{W_W{1'b0}}, w_mul_a} * {{R_W{1'b0}}, w_mul_b};
  assign w_prod_sh = ACC_W'(w_prod >> FRAC);
  // Hidden terms are exact integer products; output terms drop their fraction per term.
  assign w_term    = (r_state == OUT) ? w_prod_sh : w_prod[ACC_W-1:0];
  assign w_biased  = r_acc + (ACC_W'(w_bias) << FRAC);
  assign w_over    = (w_biased > SAT_MAX);
  assign w_result  = w_over ? SAT_MAX[R_W-1:0] : w_biased[R_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_neu   <= '0;
      r_step  <= '0;
      r_h1    <= '0;
      r_h2    <= '0;
      r_h3    <= '0;
      r_o1    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_w_err <= 1'b0;
      r_sat   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_in[i]   <= '0;
        r_bias[i] <= '0;
      end
      for (int i = 0; i < 15; i++) r_w[i] <= '0;
    end else begin
      r_done  <= 1'b0;
      r_w_err <= 1'b0;
      if (w_wr_en) begin
        if (r_state == IDLE && w_addr != 4'd15) r_w[w_addr] <= w_data;
        else r_w_err <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (start) begin
            r_in[0]   <= in1;
            r_in[1]   <= in2;
            r_in[2]   <= in3;
            r_in[3]   <= in4;
            r_bias[0] <= bias1;
            r_bias[1] <= bias2;
            r_bias[2] <= bias3;
            r_bias[3] <= bias4;
            r_acc     <= '0;
            r_sat     <= 1'b0;
            r_neu     <= '0;
            r_step    <= '0;
            r_busy    <= 1'b1;
            r_state   <= HID;
          end
        end
        HID: begin
          if (r_step == 3'd4) begin
            case (r_neu)
              2'd0:    r_h1 <= w_result;
              2'd1:    r_h2 <= w_result;
              default: r_h3 <= w_result;
            endcase
            if (w_over) r_sat <= 1'b1;
            r_acc  <= '0;
            r_step <= '0;
            if (r_neu == 2'd2) begin
              r_neu   <= '0;
              r_state <= OUT;
            end else begin
              r_neu <= r_neu + 2'd1;
            end
          end else begin
            r_acc  <= r_acc + w_term;
            r_step <= r_step + 3'd1;
          end
        end
        OUT: begin
          if (r_step == 3'd3) begin
            r_o1    <= w_result;
            if (w_over) r_sat <= 1'b1;
            r_acc   <= '0;
            r_step  <= '0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_acc  <= r_acc + w_term;
            r_step <= r_step + 3'd1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign w_err  = r_w_err;
  assign sat    = r_sat;
  assign h1_out = r_h1;
  assign h2_out = r_h2;
  assign h3_out = r_h3;
  assign out_o1 = r_o1;

endmodule
